enc_bundler_accum: RTL and testbench



---
 rtl/enc_bundler_accum_pkg.sv | 10 +
 rtl/enc_bundler_colsum.sv | 17 +
 rtl/enc_bundler_accum.sv | 106 ++++++++++
 tb/tb_enc_bundler_accum.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/enc_bundler_accum_pkg.sv
// enc_bundler_accum_pkg: shared encoder constants and bundler state encoding.
package enc_bundler_accum_pkg;
  localparam int HV_DIM = 1024;
  localparam int FEATURES_PER_CC = 62;
  localparam int SHIFTS = FEATURES_PER_CC;
  localparam int BEATS_PER_SAMPLE = 10;
  localparam int THRESHOLD = 31;
  localparam int CNT_W = $clog2(FEATURES_PER_CC * BEATS_PER_SAMPLE + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} bundler_state_t;
endpackage

// File: rtl/enc_bundler_colsum.sv
// enc_bundler_colsum: per-dimension count of set bits across one beat's bound hypervectors.
module enc_bundler_colsum #(
  parameter int HV_DIM = enc_bundler_accum_pkg::HV_DIM,
  parameter int FEATURES_PER_CC = enc_bundler_accum_pkg::FEATURES_PER_CC,
  localparam int SW = $clog2(FEATURES_PER_CC + 1)
) (
  input  logic [HV_DIM-1:0] hv  [FEATURES_PER_CC],
  output logic [SW-1:0]     sum [0:HV_DIM-1]
);
  import enc_bundler_accum_pkg::*;
  always_comb begin
    for (int d = 0; d < HV_DIM; d++) begin
      sum[d] = '0;
      for (int f = 0; f < FEATURES_PER_CC; f++) sum[d] = sum[d] + SW'(hv[f][d]);
    end
  end
endmodule

// File: rtl/enc_bundler_accum.sv
// enc_bundler_accum: accumulates bound hypervectors over a sample and thresholds them into the sample hypervector.
// Optional out_popcount output when ENC_BUNDLER_DENSITY_EN is defined.
module enc_bundler_accum #(
  parameter int HV_DIM = enc_bundler_accum_pkg::HV_DIM,
  parameter int FEATURES_PER_CC = enc_bundler_accum_pkg::FEATURES_PER_CC,
  parameter int BEATS_PER_SAMPLE = enc_bundler_accum_pkg::BEATS_PER_SAMPLE,
  parameter int THRESHOLD = enc_bundler_accum_pkg::THRESHOLD
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [HV_DIM-1:0]            shifted_hv [FEATURES_PER_CC],
  output logic                         out_valid,
  input  logic                         out_ready,
`ifdef ENC_BUNDLER_DENSITY_EN
  output logic [$clog2(HV_DIM+1)-1:0]  out_popcount,
`endif
  output logic [HV_DIM-1:0]            out_hv
);
  import enc_bundler_accum_pkg::*;
  localparam int CNT_W = $clog2(FEATURES_PER_CC * BEATS_PER_SAMPLE + 1);
  localparam int SW = $clog2(FEATURES_PER_CC + 1);
  localparam int BC_W = $clog2(BEATS_PER_SAMPLE + 1);
  bundler_state_t state_q, state_d;
  logic [BC_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] cnt_q [HV_DIM];
  logic [CNT_W-1:0] cnt_d [HV_DIM];
  logic [CNT_W-1:0] acc [HV_DIM];
  logic [SW-1:0] colsum [0:HV_DIM-1];
  logic [HV_DIM-1:0] out_hv_q, out_hv_d, thr;
  logic last;
  enc_bundler_colsum #(.HV_DIM(HV_DIM), .FEATURES_PER_CC(FEATURES_PER_CC)) u_colsum (
    .hv(shifted_hv),
    .sum(colsum)
  );
`ifdef ENC_BUNDLER_DENSITY_EN
  localparam int PC_W = $clog2(HV_DIM + 1);
  logic [PC_W-1:0] pop_q, pop_d, pop_thr;
  assign out_popcount = pop_q;
`endif
  assign in_ready = state_q != DONE;
  assign out_valid = state_q == DONE;
  assign out_hv = out_hv_q;
  always_comb begin
    state_d = state_q;
    beat_cnt_d = beat_cnt_q;
    cnt_d = cnt_q;
    out_hv_d = out_hv_q;
    // the first beat overwrites stale counters, so no clear cycle is needed between samples
    for (int d = 0; d < HV_DIM; d++) begin
      acc[d] = (state_q == IDLE ? '0 : cnt_q[d]) + CNT_W'(colsum[d]);
      thr[d] = acc[d] >= CNT_W'(THRESHOLD);
    end
    last = state_q == IDLE ? BEATS_PER_SAMPLE == 1 : beat_cnt_q == BC_W'(BEATS_PER_SAMPLE - 1);
`ifdef ENC_BUNDLER_DENSITY_EN
    pop_d = pop_q;
    pop_thr = '0;
    for (int d = 0; d < HV_DIM; d++) pop_thr = pop_thr + PC_W'(thr[d]);
`endif
    if (flush) begin
      state_d = IDLE;
      beat_cnt_d = '0;
      out_hv_d = '0;
`ifdef ENC_BUNDLER_DENSITY_EN
      pop_d = '0;
`endif
    end else if (state_q == DONE) begin
      if (out_ready) begin
        state_d = IDLE;
        out_hv_d = '0;
`ifdef ENC_BUNDLER_DENSITY_EN
        pop_d = '0;
`endif
      end
    end else if (in_valid && in_ready) begin
      cnt_d = acc;
      beat_cnt_d = last ? '0 : beat_cnt_q + 1'b1;
      state_d = last ? DONE : ACCUM;
      out_hv_d = last ? thr : out_hv_q;
`ifdef ENC_BUNDLER_DENSITY_EN
      pop_d = last ? pop_thr : pop_q;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      beat_cnt_q <= '0;
      cnt_q <= '{default: '0};
      out_hv_q <= '0;
`ifdef ENC_BUNDLER_DENSITY_EN
      pop_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      beat_cnt_q <= beat_cnt_d;
      cnt_q <= cnt_d;
      out_hv_q <= out_hv_d;
`ifdef ENC_BUNDLER_DENSITY_EN
      pop_q <= pop_d;
`endif
    end
  end
endmodule

// File: tb/tb_enc_bundler_accum.sv
// tb_enc_bundler_accum: directed and random samples checked every cycle against a count-and-threshold model.
module tb_enc_bundler_accum;
  localparam int HV = 8, F = 4, B = 2, TH = 3;
  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid;
  logic [HV-1:0] shifted_hv [F] = '{default: '0};
  logic [HV-1:0] out_hv;
`ifdef ENC_BUNDLER_DENSITY_EN
  logic [3:0] out_popcount;
`endif
  int n_chk = 0, n_pass = 0;
  int m_counts [HV];
  int m_beats;
  logic m_valid;
  logic [HV-1:0] m_hv;
  always #5 clk = ~clk;
  enc_bundler_accum #(.HV_DIM(HV), .FEATURES_PER_CC(F), .BEATS_PER_SAMPLE(B), .THRESHOLD(TH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .shifted_hv(shifted_hv), .out_valid(out_valid), .out_ready(out_ready),
`ifdef ENC_BUNDLER_DENSITY_EN
    .out_popcount(out_popcount),
`endif
    .out_hv(out_hv)
  );
  function automatic int bitsum(int d);
    int s = 0;
    for (int f = 0; f < F; f++) s += int'(shifted_hv[f][d]);
    return s;
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush) begin
      for (int d = 0; d < HV; d++) m_counts[d] <= 0;
      m_beats <= 0;
      m_valid <= 1'b0;
      m_hv <= '0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_hv <= '0;
      end
    end else if (in_valid) begin
      if (m_beats == B - 1) begin
        for (int d = 0; d < HV; d++) begin
          m_counts[d] <= 0;
          m_hv[d] <= (m_counts[d] + bitsum(d)) >= TH;
        end
        m_beats <= 0;
        m_valid <= 1'b1;
      end else begin
        for (int d = 0; d < HV; d++) m_counts[d] <= m_counts[d] + bitsum(d);
        m_beats <= m_beats + 1;
      end
    end
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  task automatic cmp();
    check("cyc_out_valid", 32'(out_valid), 32'(m_valid));
    check("cyc_in_ready", 32'(in_ready), 32'(!m_valid));
    check("cyc_out_hv", 32'(out_hv), 32'(m_hv));
`ifdef ENC_BUNDLER_DENSITY_EN
    check("cyc_popcount", 32'(out_popcount), 32'($countones(m_hv)));
`endif
  endtask
  task automatic tick();
    @(negedge clk);
    cmp();
    @(posedge clk);
    #1;
  endtask
  task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    shifted_hv = '{a, b, c, d};
    in_valid = 1;
    check("beat_in_ready", 32'(in_ready), 1);
    tick();
    in_valid = 0;
    shifted_hv = '{default: '0};
  endtask
  task automatic expect_done(input string name, input logic [7:0] hv, input int pop);
    check({name, "_valid"}, 32'(out_valid), 1);
    check({name, "_hv"}, 32'(out_hv), 32'(hv));
`ifdef ENC_BUNDLER_DENSITY_EN
    check({name, "_pop"}, 32'(out_popcount), 32'(pop));
`endif
  endtask
  task automatic take();
    out_ready = 1;
    tick();
    out_ready = 0;
    check("take_in_ready", 32'(in_ready), 1);
    check("take_out_valid", 32'(out_valid), 0);
    check("take_out_hv", 32'(out_hv), 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_hv", 32'(out_hv), 0);
    rst_n = 1;
    tick();
    beat(8'h0F, 8'h0F, 8'h0F, 8'h0F);
    beat(8'hF0, 8'h00, 8'h00, 8'h00);
    expect_done("basic", 8'h0F, 4);
    take();
    beat(8'h01, 8'h01, 8'h01, 8'h00);
    beat(8'h81, 8'h00, 8'h00, 8'h00);
    expect_done("bit0", 8'h01, 1);
    take();
    beat(8'h0F, 8'h0F, 8'h0F, 8'h0F);
    beat(8'hF0, 8'h00, 8'h00, 8'h00);
    in_valid = 1;
    shifted_hv = '{default: 8'hFF};
    for (int i = 0; i < 5; i++) begin
      tick();
      expect_done("hold", 8'h0F, 4);
      check("hold_in_ready", 32'(in_ready), 0);
    end
    in_valid = 0;
    shifted_hv = '{default: '0};
    take();
    beat(8'h0F, 8'h0F, 8'h0F, 8'h0F);
    repeat (3) tick();
    beat(8'hF0, 8'h00, 8'h00, 8'h00);
    expect_done("gap", 8'h0F, 4);
    take();
    beat(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    flush = 1;
    tick();
    flush = 0;
    check("flush_in_ready", 32'(in_ready), 1);
    beat(8'h01, 8'h01, 8'h01, 8'h00);
    beat(8'h81, 8'h00, 8'h00, 8'h00);
    expect_done("after_flush", 8'h01, 1);
    flush = 1;
    out_ready = 1;
    tick();
    flush = 0;
    out_ready = 0;
    check("flush_done_valid", 32'(out_valid), 0);
    flush = 1;
    beat(8'hFF, 8'hFF, 8'hFF, 8'hFF);
    flush = 0;
    beat(8'h3C, 8'h3C, 8'h0C, 8'h00);
    beat(8'h04, 8'h00, 8'h00, 8'h00);
    expect_done("flush_beat_dropped", 8'h0C, 2);
    take();
    for (int s = 0; s < 6; s++) begin
      for (int b = 0; b < B; b++)
        beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      check("rand_valid", 32'(out_valid), 1);
      take();
    end
    beat(8'h0F, 8'h0F, 8'h0F, 8'h0F);
    beat(8'hF0, 8'h00, 8'h00, 8'h00);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_out_hv", 32'(out_hv), 0);
    check("arst_in_ready", 32'(in_ready), 1);
    @(posedge clk);
    #1 rst_n = 1;
    tick();
    check("post_rst_in_ready", 32'(in_ready), 1);
    beat(8'h01, 8'h01, 8'h01, 8'h00);
    beat(8'h81, 8'h00, 8'h00, 8'h00);
    expect_done("post_rst", 8'h01, 1);
    take();
    tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
